fifo_unpacker: RTL and testbench



---
 rtl/fifo_unpacker.sv | 111 +++++++++++
 tb/tb_fifo_unpacker.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_unpacker.sv
// Pops WIDTH-bit words from a FIFO read port and re-emits each one as
// OUT_WIDTH-bit valid/ready beats, most-significant beat first.
module fifo_unpacker #(
    parameter int WIDTH     = 32,
    parameter int OUT_WIDTH = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fifo_empty,
    input  logic [WIDTH-1:0]     fifo_dout,
    output logic                 fifo_read_en,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] word_cnt
);

    localparam int BEATS = WIDTH / OUT_WIDTH;
    localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_SHIFT = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     word_q, word_d;
    logic [IDX_W-1:0]     beat_idx_q, beat_idx_d;
    logic [CNT_WIDTH-1:0] word_cnt_q, word_cnt_d;
    logic [WIDTH-1:0]     word_shifted;
    logic                 is_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            word_q     <= '0;
            beat_idx_q <= '0;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            beat_idx_q <= beat_idx_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    // Shifting the held word left puts the current beat in the top OUT_WIDTH bits.
    always_comb begin
        word_shifted = word_q << (OUT_WIDTH * int'(beat_idx_q));
        is_last      = (beat_idx_q == IDX_W'(BEATS - 1));
    end

    always_comb begin
        state_d      = state_q;
        word_d       = word_q;
        beat_idx_d   = beat_idx_q;
        word_cnt_d   = word_cnt_q;
        fifo_read_en = 1'b0;
        out_valid    = 1'b0;
        out_last     = 1'b0;
        out_data     = '0;

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    fifo_read_en = 1'b1;
                    state_d      = S_WAIT;
                end
            end
            S_WAIT: begin
                word_d     = fifo_dout;
                beat_idx_d = '0;
                state_d    = S_SHIFT;
            end
            S_SHIFT: begin
                out_valid = 1'b1;
                out_last  = is_last;
                out_data  = word_shifted[WIDTH-1 -: OUT_WIDTH];
                if (out_ready) begin
                    if (is_last) begin
                        word_cnt_d = word_cnt_q + CNT_WIDTH'(1);
                        if (!fifo_empty) begin
                            fifo_read_en = 1'b1;
                            state_d      = S_WAIT;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        beat_idx_d = beat_idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A pop issued during reset would return a word nobody captures.
        if (rst) begin
            fifo_read_en = 1'b0;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign word_cnt = word_cnt_q;

endmodule

// File: tb/tb_fifo_unpacker.sv
// Directed bench for fifo_unpacker with a behavioural FIFO model that pops
// on fifo_read_en and presents the word on fifo_dout the following cycle.
module tb_fifo_unpacker;

    logic        clk;
    logic        rst;
    logic        fifo_empty;
    logic [31:0] fifo_dout;
    logic        fifo_read_en;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;
    logic [15:0] word_cnt;

    fifo_unpacker #(
        .WIDTH(32),
        .OUT_WIDTH(8),
        .CNT_WIDTH(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .fifo_empty(fifo_empty),
        .fifo_dout(fifo_dout),
        .fifo_read_en(fifo_read_en),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last(out_last),
        .busy(busy),
        .word_cnt(word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checkCount = 0;
    int passCount  = 0;
    int rdCount    = 0;
    int illegalReads = 0;

    logic [31:0] fifoQ[$];
    logic [31:0] beatLog[$];
    logic [31:0] lastLog[$];

    logic [31:0] sRd, sValid, sData, sLast, sBusy, sCnt;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Samples one cycle at the falling edge, then advances the FIFO model past the rising edge.
    task automatic stepCycle();
        @(negedge clk);
        sRd    = 32'(fifo_read_en);
        sValid = 32'(out_valid);
        sData  = 32'(out_data);
        sLast  = 32'(out_last);
        sBusy  = 32'(busy);
        sCnt   = 32'(word_cnt);
        if (fifo_read_en) rdCount++;
        if (fifo_read_en && fifo_empty) illegalReads++;
        if (out_valid && out_ready && !rst) begin
            beatLog.push_back(32'(out_data));
            lastLog.push_back(32'(out_last));
        end
        @(posedge clk);
        #1;
        if (sRd[0] && fifoQ.size() > 0) begin
            fifo_dout = fifoQ.pop_front();
        end
        fifo_empty = (fifoQ.size() == 0);
    endtask

    task automatic pushWord(input logic [31:0] w);
        fifoQ.push_back(w);
        fifo_empty = 1'b0;
    endtask

    task automatic applyStimulus(input bit doReset);
        if (doReset) begin
            rst = 1'b1;
            fifoQ.delete();
            fifo_empty = 1'b1;
            out_ready  = 1'b1;
            stepCycle();
            stepCycle();
            rst = 1'b0;
        end
        beatLog.delete();
        lastLog.delete();
        rdCount = 0;
    endtask

    task automatic runUntilIdle(input string tag, input int maxCycles, input bit randReady);
        int n = 0;
        out_ready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
        stepCycle();
        while (!(sBusy == 0 && sRd == 0 && fifoQ.size() == 0) && n < maxCycles) begin
            out_ready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
            stepCycle();
            n++;
        end
        out_ready = 1'b1;
        checkOutput({tag, "Finished"}, 32'(n < maxCycles), 1);
    endtask

    initial begin
        logic [31:0] expRd[7]    = '{0: 1, 1: 0, 2: 0, 3: 0, 4: 0, 5: 0, 6: 0};
        logic [31:0] expValid[7] = '{0: 0, 1: 0, 2: 1, 3: 1, 4: 1, 5: 1, 6: 0};
        logic [31:0] expData[7]  = '{0: 0, 1: 0, 2: 'hA1, 3: 'hB2, 4: 'hC3, 5: 'hD4, 6: 0};
        logic [31:0] expLast[7]  = '{0: 0, 1: 0, 2: 0, 3: 0, 4: 0, 5: 1, 6: 0};
        logic [31:0] expBusy[7]  = '{0: 0, 1: 1, 2: 1, 3: 1, 4: 1, 5: 1, 6: 0};
        logic [31:0] b2b[8]      = '{'hB2, 'hB2, 'hB2, 'hB2, 'hC3, 'hC3, 'hC3, 'hC3};
        logic [31:0] rstExp[5]   = '{'h11, 'h55, 'h66, 'h77, 'h88};
        logic [31:0] stressWords[$];
        logic [31:0] expBeats[$];
        int anyActive;
        int errs;

        rst        = 1'b1;
        fifo_empty = 1'b1;
        fifo_dout  = '0;
        out_ready  = 1'b1;

        // Reset state
        applyStimulus(1'b1);
        stepCycle();
        checkOutput("resetRd", sRd, 0);
        checkOutput("resetValid", sValid, 0);
        checkOutput("resetLast", sLast, 0);
        checkOutput("resetData", sData, 0);
        checkOutput("resetBusy", sBusy, 0);
        checkOutput("resetCnt", sCnt, 0);

        // Single word, cycle-by-cycle against a hand-built timeline
        applyStimulus(1'b1);
        pushWord(32'hA1B2C3D4);
        for (int i = 0; i < 7; i++) begin
            stepCycle();
            checkOutput($sformatf("single%0dRd", i), sRd, expRd[i]);
            checkOutput($sformatf("single%0dValid", i), sValid, expValid[i]);
            checkOutput($sformatf("single%0dData", i), sData, expData[i]);
            checkOutput($sformatf("single%0dLast", i), sLast, expLast[i]);
            checkOutput($sformatf("single%0dBusy", i), sBusy, expBusy[i]);
        end
        checkOutput("singleCnt", sCnt, 1);
        checkOutput("singleReads", 32'(rdCount), 1);

        // Back-to-back words: second pop on the last-beat handshake, one bubble
        applyStimulus(1'b1);
        pushWord(32'hB2B2B2B2);
        pushWord(32'hC3C3C3C3);
        for (int i = 0; i < 11; i++) begin
            stepCycle();
            if (i == 5) begin
                checkOutput("b2bSecondRd", sRd, 1);
                checkOutput("b2bSecondRdLast", sLast, 1);
            end
            if (i == 6) checkOutput("b2bBubble", sValid, 0);
            if (i == 7) checkOutput("b2bResume", sValid, 1);
        end
        runUntilIdle("b2b", 20, 1'b0);
        checkOutput("b2bBeatCount", 32'(beatLog.size()), 8);
        for (int i = 0; i < 8 && i < beatLog.size(); i++) begin
            checkOutput($sformatf("b2bBeat%0d", i), beatLog[i], b2b[i]);
        end
        checkOutput("b2bCnt", sCnt, 2);
        checkOutput("b2bReads", 32'(rdCount), 2);

        // Backpressure on the second beat
        applyStimulus(1'b1);
        pushWord(32'hD4D4D4D4);
        stepCycle();
        stepCycle();
        stepCycle();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            stepCycle();
            checkOutput($sformatf("bpValid%0d", i), sValid, 1);
            checkOutput($sformatf("bpData%0d", i), sData, 'hD4);
            checkOutput($sformatf("bpLast%0d", i), sLast, 0);
            checkOutput($sformatf("bpRd%0d", i), sRd, 0);
        end
        out_ready = 1'b1;
        runUntilIdle("bp", 20, 1'b0);
        checkOutput("bpBeatCount", 32'(beatLog.size()), 4);
        checkOutput("bpLastFlag", (lastLog.size() == 4) ? lastLog[3] : 32'hFFFF, 1);
        checkOutput("bpReads", 32'(rdCount), 1);
        checkOutput("bpCnt", sCnt, 1);

        // Empty FIFO for 20 cycles after reset
        applyStimulus(1'b1);
        anyActive = 0;
        for (int i = 0; i < 20; i++) begin
            stepCycle();
            if (sRd != 0 || sValid != 0 || sBusy != 0 || sCnt != 0) anyActive++;
        end
        checkOutput("emptyActivity", 32'(anyActive), 0);
        checkOutput("emptyCnt", sCnt, 0);

        // Reset during the second beat drops the word; the next word comes out whole
        applyStimulus(1'b1);
        pushWord(32'h11223344);
        pushWord(32'h55667788);
        stepCycle();
        stepCycle();
        stepCycle();
        rst = 1'b1;
        stepCycle();
        checkOutput("midRstRdForced", sRd, 0);
        rst = 1'b0;
        stepCycle();
        checkOutput("midRstValid", sValid, 0);
        checkOutput("midRstBusy", sBusy, 0);
        checkOutput("midRstCnt", sCnt, 0);
        runUntilIdle("midRst", 20, 1'b0);
        checkOutput("midRstBeatCount", 32'(beatLog.size()), 5);
        for (int i = 0; i < 5 && i < beatLog.size(); i++) begin
            checkOutput($sformatf("midRstBeat%0d", i), beatLog[i], rstExp[i]);
        end
        checkOutput("midRstCntAfter", sCnt, 1);

        // Fill-then-drain with random sink readiness
        applyStimulus(1'b1);
        for (int i = 0; i < 32; i++) begin
            logic [31:0] w;
            w = $urandom;
            stressWords.push_back(w);
            pushWord(w);
            for (int b = 0; b < 4; b++) begin
                expBeats.push_back((w >> (24 - 8 * b)) & 32'hFF);
            end
        end
        runUntilIdle("stress", 3000, 1'b1);
        checkOutput("stressBeatCount", 32'(beatLog.size()), 128);
        errs = 0;
        for (int i = 0; i < 128; i++) begin
            if (i >= beatLog.size()) begin
                errs++;
            end else begin
                if (beatLog[i] !== expBeats[i]) errs++;
                if (lastLog[i] !== 32'((i % 4) == 3)) errs++;
            end
        end
        checkOutput("stressBeatErrors", 32'(errs), 0);
        checkOutput("stressCnt", sCnt, 32);
        checkOutput("stressReads", 32'(rdCount), 32);

        checkOutput("readWhileEmpty", 32'(illegalReads), 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
